// File: rtl/asd_conv_arbiter.sv
// Round-robin arbiter sharing one ASD/CSD conversion engine among N_REQ requesters, with watchdog abort.
// Latency: grant 1 cycle after req seen in IDLE; response 1 cycle after conv_done; engine held until done.
module asd_conv_arbiter #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 8,
    parameter int RES_W   = 18,
    parameter int CNT_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [N_REQ-1:0]           req_i,
    input  logic [N_REQ*WIDTH-1:0]     req_data_i,
    output logic [N_REQ-1:0]           ack_o,
    output logic                       resp_valid_o,
    output logic [$clog2(N_REQ)-1:0]   resp_id_o,
    output logic [RES_W-1:0]           resp_result_o,
    output logic [CNT_W-1:0]           resp_nz_o,
    output logic                       resp_err_o,
    output logic                       busy_o,
    output logic                       conv_start_o,
    output logic [WIDTH-1:0]           conv_operand_o,
    output logic                       conv_rst_o,
    input  logic                       conv_done_i,
    input  logic [RES_W-1:0]           conv_result_i,
    input  logic [CNT_W-1:0]           conv_nz_i
);
    localparam int ID_W  = $clog2(N_REQ);
    localparam int TMR_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   id_q, id_d, last_id_q, last_id_d;
    logic [WIDTH-1:0]  op_q, op_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [ID_W-1:0]   rid_q, rid_d;
    logic [RES_W-1:0]  rres_q, rres_d;
    logic [CNT_W-1:0]  rnz_q, rnz_d;
    logic              rerr_q, rerr_d;

    logic              win_vld;
    logic [ID_W-1:0]   win_id;
    logic [ID_W-1:0]   cand_id;
    logic [WIDTH-1:0]  win_op;
    int                cand;

    // Search starts just after the last served requester so a requester holding req waits its turn.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        cand    = 0;
        cand_id = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = int'(last_id_q) + k;
            if (cand >= N_REQ) cand = cand - N_REQ;
            cand_id = ID_W'(cand);
            if (!win_vld && req_i[cand_id]) begin
                win_vld = 1'b1;
                win_id  = cand_id;
            end
        end
        win_op = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (win_id == ID_W'(k)) win_op = req_data_i[k*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        last_id_d = last_id_q;
        op_d      = op_q;
        tmr_d     = tmr_q;
        rid_d     = rid_q;
        rres_d    = rres_q;
        rnz_d     = rnz_q;
        rerr_d    = rerr_q;
        case (state_q)
            S_IDLE: begin
                if (win_vld) begin
                    id_d    = win_id;
                    op_d    = win_op;
                    tmr_d   = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                tmr_d = tmr_q + 1'b1;
                // A done arriving on the last watchdog cycle still counts as a good result.
                if (conv_done_i) begin
                    rid_d   = id_q;
                    rres_d  = conv_result_i;
                    rnz_d   = conv_nz_i;
                    rerr_d  = 1'b0;
                    state_d = S_RESP;
                end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
                    rid_d   = id_q;
                    rres_d  = '0;
                    rnz_d   = '0;
                    rerr_d  = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                last_id_d = id_q;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            id_q      <= '0;
            last_id_q <= ID_W'(N_REQ - 1);
            op_q      <= '0;
            tmr_q     <= '0;
            rid_q     <= '0;
            rres_q    <= '0;
            rnz_q     <= '0;
            rerr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            last_id_q <= last_id_d;
            op_q      <= op_d;
            tmr_q     <= tmr_d;
            rid_q     <= rid_d;
            rres_q    <= rres_d;
            rnz_q     <= rnz_d;
            rerr_q    <= rerr_d;
        end
    end

    // Pulses and the start level are masked by reset so a discarded job never reaches the requester.
    assign busy_o         = (state_q != S_IDLE);
    assign conv_start_o   = (state_q == S_BUSY) && !reset_i;
    assign resp_valid_o   = (state_q == S_RESP) && !reset_i;
    assign conv_rst_o     = reset_i || ((state_q == S_RESP) && rerr_q);
    assign conv_operand_o = op_q;
    assign resp_id_o      = rid_q;
    assign resp_result_o  = rres_q;
    assign resp_nz_o      = rnz_q;
    assign resp_err_o     = rerr_q;

    always_comb begin
        ack_o = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (resp_valid_o && (id_q == ID_W'(k))) ack_o[k] = 1'b1;
        end
    end

endmodule

// File: tb/tb_asd_conv_arbiter.sv
// Bench for asd_conv_arbiter: job table, hand-written reset/corner sequences, then random jobs vs a round-robin model.
module tb_asd_conv_arbiter;
    localparam int N  = 4;
    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic        conv_done;
    logic [17:0] conv_result;
    logic [3:0]  conv_nz;
    logic [3:0]  ack;
    logic        resp_valid;
    logic [1:0]  resp_id;
    logic [17:0] resp_result;
    logic [3:0]  resp_nz;
    logic        resp_err;
    logic        busy;
    logic        conv_start;
    logic [7:0]  conv_operand;
    logic        conv_rst;

    always #5 clk = ~clk;

    asd_conv_arbiter dut (
        .clk_i(clk), .reset_i(reset), .req_i(req), .req_data_i(req_data),
        .ack_o(ack), .resp_valid_o(resp_valid), .resp_id_o(resp_id),
        .resp_result_o(resp_result), .resp_nz_o(resp_nz), .resp_err_o(resp_err),
        .busy_o(busy), .conv_start_o(conv_start), .conv_operand_o(conv_operand),
        .conv_rst_o(conv_rst), .conv_done_i(conv_done), .conv_result_i(conv_result),
        .conv_nz_i(conv_nz)
    );

    int n_vec = 0;
    int n_err = 0;
    int eng_delay = 0, eng_cnt = 0, gap = 0, start_len = 0, last_model = 3;
    bit prev_start = 0, have_prev = 0, got_vld = 0;
    logic [1:0]  got_id;
    logic [17:0] got_res;
    logic [3:0]  got_nz, got_ack;
    logic        got_err, got_rst;
    logic [7:0]  got_op;

    typedef struct {
        bit         rst;
        logic [3:0] req;
        int         delay;
        bit         mess;
        int         exp_id;
        bit         exp_err;
    } vec_t;
    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [17:0] eng_res(input logic [7:0] op);
        return {op, 10'h155};
    endfunction

    function automatic logic [3:0] eng_nz(input logic [7:0] op);
        return {1'b1, op[2:0]};
    endfunction

    // Reference round robin: the winner is the set requester closest after the last one served.
    function automatic int rr_pick(input logic [3:0] m, input int last);
        int best, bestd, d;
        best = -1; bestd = N;
        for (int i = 0; i < N; i++) begin
            d = (i - last - 1 + 2 * N) % N;
            if (m[i] && d < bestd) begin
                bestd = d;
                best  = i;
            end
        end
        return best;
    endfunction

    // One cycle: sample at negedge, then play the engine and record responses.
    task automatic step();
        @(negedge clk);
        if (conv_start) begin
            if (!prev_start) begin
                if (have_prev) chk("start_gap", (gap >= 2), 1);
                start_len = 0;
                got_op    = conv_operand;
            end
            start_len++;
            eng_cnt++;
            conv_done = (eng_cnt == eng_delay);
            gap = 0;
        end else begin
            eng_cnt   = 0;
            conv_done = 1'b0;
            gap++;
        end
        conv_result = conv_done ? eng_res(conv_operand) : '1;
        conv_nz     = conv_done ? eng_nz(conv_operand) : '1;
        if (resp_valid) begin
            got_vld = 1; got_id = resp_id; got_res = resp_result; got_nz = resp_nz;
            got_err = resp_err; got_ack = ack; got_rst = conv_rst; have_prev = 1;
        end
        prev_start = conv_start;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        step();
        chk("rst_conv_rst_hi", conv_rst, 1);
        step();
        chk("rst_outputs", {busy, conv_start, resp_valid, ack, resp_err, resp_id, resp_nz, conv_operand}, 0);
        chk("rst_result", resp_result, 0);
        reset = 1'b0;
        have_prev = 0;
        step();
        chk("rst_conv_rst_lo", conv_rst, 0);
        last_model = 3;
    endtask

    task automatic run_job(input int delay, input bit mess, input int exp_id, input bit exp_err);
        logic [7:0] exp_op;
        int guard;
        exp_op    = req_data[exp_id*8 +: 8];
        eng_delay = delay;
        got_vld   = 0;
        guard     = 0;
        while (!got_vld && guard < 300) begin
            step();
            guard++;
            if (mess && conv_start && start_len == 1) begin
                req_data    = $urandom;
                req[exp_id] = 1'b0;
            end
        end
        if (!got_vld) begin
            n_vec++;
            n_err++;
            $display("FAIL resp_timeout: no resp_valid within %0d cycles, expected id %0d", guard, exp_id);
        end else begin
            chk("resp_id", got_id, exp_id);
            chk("resp_err", got_err, exp_err);
            chk("resp_result", got_res, exp_err ? 18'h0 : eng_res(exp_op));
            chk("resp_nz", got_nz, exp_err ? 4'h0 : eng_nz(exp_op));
            chk("ack", got_ack, 1 << exp_id);
            chk("operand", got_op, exp_op);
            chk("operand_hold", conv_operand, exp_op);
            chk("start_len", start_len, exp_err ? TO : delay);
            chk("conv_rst_resp", got_rst, exp_err);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] m;
        int d, id;
        bit mz;
        reset = 1'b1; req = '0; req_data = 32'h1122_AB37;
        conv_done = 1'b0; conv_result = '0; conv_nz = '0;

        //          rst  req      delay mess id err
        tbl[0]  = '{1, 4'b0001, 10, 0, 0, 0};
        tbl[1]  = '{1, 4'b1111,  5, 0, 0, 0};
        tbl[2]  = '{0, 4'b1111,  5, 0, 1, 0};
        tbl[3]  = '{0, 4'b1111,  5, 0, 2, 0};
        tbl[4]  = '{0, 4'b1111,  5, 0, 3, 0};
        tbl[5]  = '{0, 4'b1111,  5, 0, 0, 0};
        tbl[6]  = '{0, 4'b1010,  3, 0, 1, 0};
        tbl[7]  = '{0, 4'b1010,  3, 0, 3, 0};
        tbl[8]  = '{0, 4'b0010,  0, 0, 1, 1};
        tbl[9]  = '{0, 4'b0100, 64, 0, 2, 0};
        tbl[10] = '{0, 4'b0100,  2, 1, 2, 0};
        tbl[11] = '{0, 4'b1001,  1, 0, 3, 0};
        tbl[12] = '{0, 4'b1001,  1, 0, 0, 0};

        for (int i = 0; i < 13; i++) begin
            if (tbl[i].rst) do_reset();
            req = tbl[i].req;
            run_job(tbl[i].delay, tbl[i].mess, tbl[i].exp_id, tbl[i].exp_err);
            last_model = tbl[i].exp_id;
        end

        // Response fields hold after the pulse; a stray done while idle is ignored.
        req = '0;
        step();
        chk("hold_pulses", {resp_valid, ack}, 0);
        chk("hold_resp_id", resp_id, 0);
        chk("hold_resp_err", resp_err, 0);
        conv_done   = 1'b1;
        conv_result = 18'h0;
        @(negedge clk);
        chk("idle_done_ignored", {busy, resp_valid}, 0);
        step();

        // Reset in BUSY cycle 3 discards the job.
        req = 4'b0100; eng_delay = 10; got_vld = 0;
        for (int g = 0; g < 10 && !conv_start; g++) step();
        step();
        step();
        chk("t5_busy_c3", {conv_start, start_len[3:0]}, {1'b1, 4'd3});
        reset = 1'b1;
        req   = '0;
        #1;
        chk("t5_conv_rst", conv_rst, 1);
        chk("t5_pulses_in_rst", {resp_valid, ack}, 0);
        step();
        chk("t5_after_rst", {conv_start, busy, resp_valid, ack}, 0);
        reset = 1'b0;
        for (int g = 0; g < 6; g++) step();
        chk("t5_no_resp", got_vld, 0);
        have_prev  = 0;
        last_model = 3;

        for (int j = 0; j < 40; j++) begin
            req_data = $urandom;
            m  = 4'($urandom_range(1, 15));
            d  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 12));
            mz = ($urandom_range(0, 3) == 0);
            id = rr_pick(m, last_model);
            req = m;
            run_job(d, mz, id, (d == 0));
            last_model = id;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
